// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing one 2R/1W register file between requesters A and B.
// Read data from the register file is routed back to whichever side owned the transaction.
module regfile_port_arbiter #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_rs1,
   input  logic [ADDR_W-1:0] a_rs2,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_rd,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_rsp_valid,
   output logic [DATA_W-1:0] a_rdata1,
   output logic [DATA_W-1:0] a_rdata2,

   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_rs1,
   input  logic [ADDR_W-1:0] b_rs2,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_rd,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_rsp_valid,
   output logic [DATA_W-1:0] b_rdata1,
   output logic [DATA_W-1:0] b_rdata2,

   output logic [ADDR_W-1:0] rf_read1,
   output logic [ADDR_W-1:0] rf_read2,
   output logic [ADDR_W-1:0] rf_write,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              rf_we,
   input  logic [DATA_W-1:0] rf_rdata1,
   input  logic [DATA_W-1:0] rf_rdata2
);

   logic prio_q, prio_d;
   logic rsp_pend_q, rsp_pend_d;
   logic rsp_owner_q, rsp_owner_d;
   logic accept;

   // Grants depend only on the valids and prio, never on the other side's ready.
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      if (!rst) begin
         a_ready = a_valid && (!b_valid || !prio_q);
         b_ready = b_valid && (!a_valid || prio_q);
      end
   end

   assign accept = a_ready || b_ready;

   always_comb begin
      rf_read1 = '0;
      rf_read2 = '0;
      rf_write = '0;
      rf_wdata = '0;
      rf_we    = 1'b0;
      if (a_ready) begin
         rf_read1 = a_rs1;
         rf_read2 = a_rs2;
         rf_write = a_rd;
         rf_wdata = a_wdata;
         rf_we    = a_we && (a_rd != '0);
      end else if (b_ready) begin
         rf_read1 = b_rs1;
         rf_read2 = b_rs2;
         rf_write = b_rd;
         rf_wdata = b_wdata;
         rf_we    = b_we && (b_rd != '0);
      end
   end

   always_comb begin
      prio_d      = prio_q;
      rsp_pend_d  = accept;
      rsp_owner_d = rsp_owner_q;
      if (accept) begin
         prio_d      = ~b_ready;
         rsp_owner_d = b_ready;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q      <= 1'b0;
         rsp_pend_q  <= 1'b0;
         rsp_owner_q <= 1'b0;
      end else begin
         prio_q      <= prio_d;
         rsp_pend_q  <= rsp_pend_d;
         rsp_owner_q <= rsp_owner_d;
      end
   end

   // Gating by rst drops a response that was pending when reset arrived.
   always_comb begin
      a_rsp_valid = !rst && rsp_pend_q && !rsp_owner_q;
      b_rsp_valid = !rst && rsp_pend_q && rsp_owner_q;
      a_rdata1    = a_rsp_valid ? rf_rdata1 : '0;
      a_rdata2    = a_rsp_valid ? rf_rdata2 : '0;
      b_rdata1    = b_rsp_valid ? rf_rdata1 : '0;
      b_rdata2    = b_rsp_valid ? rf_rdata2 : '0;
   end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: directed scenarios then random traffic, every cycle checked
// against a transaction-level model of the shared register file.
module tb_regfile_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, a_ready, a_we, a_rsp_valid;
   logic [4:0]  a_rs1, a_rs2, a_rd;
   logic [31:0] a_wdata, a_rdata1, a_rdata2;
   logic        b_valid, b_ready, b_we, b_rsp_valid;
   logic [4:0]  b_rs1, b_rs2, b_rd;
   logic [31:0] b_wdata, b_rdata1, b_rdata2;
   logic [4:0]  rf_read1, rf_read2, rf_write;
   logic [31:0] rf_wdata, rf_rdata1, rf_rdata2;
   logic        rf_we;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   regfile_port_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_rs1(a_rs1), .a_rs2(a_rs2), .a_we(a_we),
      .a_rd(a_rd), .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid), .a_rdata1(a_rdata1),
      .a_rdata2(a_rdata2),
      .b_valid(b_valid), .b_ready(b_ready), .b_rs1(b_rs1), .b_rs2(b_rs2), .b_we(b_we),
      .b_rd(b_rd), .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid), .b_rdata1(b_rdata1),
      .b_rdata2(b_rdata2),
      .rf_read1(rf_read1), .rf_read2(rf_read2), .rf_write(rf_write), .rf_wdata(rf_wdata),
      .rf_we(rf_we), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
   );

   // Environment: the register file itself (registered read, old data on same-cycle write).
   logic [31:0] rf_mem [32];
   initial for (int i = 0; i < 32; i++) rf_mem[i] = '0;
   always @(posedge clk) begin
      rf_rdata1 <= (rf_read1 == 5'd0) ? 32'd0 : rf_mem[rf_read1];
      rf_rdata2 <= (rf_read2 == 5'd0) ? 32'd0 : rf_mem[rf_read2];
      if (rf_we) rf_mem[rf_write] <= rf_wdata;
   end

   // Reference model: architectural register contents, turn pointer and the one pending reply.
   logic [31:0] m_regs [32];
   int          m_turn_b;
   int          m_pend;
   int          m_pend_b;
   logic [31:0] m_pend_d1, m_pend_d2;
   int          a_won, b_won;
   string       grant_log;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] r);
      return (r == 5'd0) ? 32'd0 : m_regs[r];
   endfunction

   task automatic cycle();
      int          win;  // 0 none, 1 A, 2 B
      logic [31:0] e_r1, e_r2, e_w, e_wd;
      logic        e_we;
      @(negedge clk);
      win = 0;
      if (!rst) begin
         if (a_valid && b_valid) win = (m_turn_b != 0) ? 2 : 1;
         else if (a_valid)       win = 1;
         else if (b_valid)       win = 2;
      end
      e_r1 = '0; e_r2 = '0; e_w = '0; e_wd = '0; e_we = 1'b0;
      if (win == 1) begin
         e_r1 = 32'(a_rs1); e_r2 = 32'(a_rs2); e_w = 32'(a_rd); e_wd = a_wdata;
         e_we = a_we && (a_rd != 5'd0);
      end else if (win == 2) begin
         e_r1 = 32'(b_rs1); e_r2 = 32'(b_rs2); e_w = 32'(b_rd); e_wd = b_wdata;
         e_we = b_we && (b_rd != 5'd0);
      end
      check_eq("a_ready", 32'(a_ready), 32'(win == 1));
      check_eq("b_ready", 32'(b_ready), 32'(win == 2));
      check_eq("rf_read1", 32'(rf_read1), e_r1);
      check_eq("rf_read2", 32'(rf_read2), e_r2);
      check_eq("rf_write", 32'(rf_write), e_w);
      check_eq("rf_wdata", rf_wdata, e_wd);
      check_eq("rf_we", 32'(rf_we), 32'(e_we));
      begin
         logic ea, eb;
         ea = !rst && (m_pend != 0) && (m_pend_b == 0);
         eb = !rst && (m_pend != 0) && (m_pend_b != 0);
         check_eq("a_rsp_valid", 32'(a_rsp_valid), 32'(ea));
         check_eq("b_rsp_valid", 32'(b_rsp_valid), 32'(eb));
         check_eq("a_rdata1", a_rdata1, ea ? m_pend_d1 : 32'd0);
         check_eq("a_rdata2", a_rdata2, ea ? m_pend_d2 : 32'd0);
         check_eq("b_rdata1", b_rdata1, eb ? m_pend_d1 : 32'd0);
         check_eq("b_rdata2", b_rdata2, eb ? m_pend_d2 : 32'd0);
      end
      a_won = (win == 1);
      b_won = (win == 2);
      if (win == 1) grant_log = {grant_log, "A"};
      else if (win == 2) grant_log = {grant_log, "B"};
      @(posedge clk);
      if (rst) begin
         m_turn_b = 0;
         m_pend   = 0;
      end else begin
         m_pend = (win != 0);
         if (win != 0) begin
            m_pend_b  = (win == 2);
            m_pend_d1 = m_read(e_r1[4:0]);
            m_pend_d2 = m_read(e_r2[4:0]);
            if (e_we) m_regs[e_w[4:0]] = e_wd;
            m_turn_b  = (win == 1);
         end
      end
      #1;
   endtask

   task automatic set_a(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic we, input logic [4:0] rd, input logic [31:0] wd);
      a_valid = v; a_rs1 = rs1; a_rs2 = rs2; a_we = we; a_rd = rd; a_wdata = wd;
   endtask

   task automatic set_b(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic we, input logic [4:0] rd, input logic [31:0] wd);
      b_valid = v; b_rs1 = rs1; b_rs2 = rs2; b_we = we; b_rd = rd; b_wdata = wd;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_turn_b = 0; m_pend = 0; m_pend_b = 0; m_pend_d1 = '0; m_pend_d2 = '0;
      a_won = 0; b_won = 0;
      grant_log = "";
      rst = 1'b1;
      set_a(0, 0, 0, 0, 0, 0);
      set_b(0, 0, 0, 0, 0, 0);
      // Requests asserted during reset must see ready=0.
      cycle();
      set_a(1, 3, 4, 1, 9, 32'h1234);
      set_b(1, 1, 2, 0, 0, 0);
      cycle();
      rst = 1'b0;
      set_a(0, 0, 0, 0, 0, 0);
      set_b(0, 0, 0, 0, 0, 0);
      cycle();

      // 1: A writes r5 while reading r0/r0.
      set_a(1, 0, 0, 1, 5, 32'hAA);
      cycle();
      // 2: B reads r5 right after.
      set_a(0, 0, 0, 0, 0, 0);
      set_b(1, 5, 0, 0, 0, 0);
      cycle();
      set_b(0, 0, 0, 0, 0, 0);
      cycle();
      check_eq("t2_r5_written", m_regs[5], 32'hAA);

      // 3: both valid for 6 cycles; payloads held so waiting requests stay stable.
      grant_log = "";
      set_a(1, 5, 1, 0, 0, 0);
      set_b(1, 2, 5, 0, 0, 0);
      for (int i = 0; i < 6; i++) cycle();
      check_eq("t3_grant_order", 32'(grant_log == "ABABAB"), 32'd1);
      set_a(0, 0, 0, 0, 0, 0);
      set_b(0, 0, 0, 0, 0, 0);
      cycle();

      // 4: read-during-write of r7, then re-read.
      set_a(1, 7, 7, 1, 7, 32'h55);
      cycle();
      set_a(1, 7, 0, 0, 0, 0);
      cycle();
      set_a(0, 0, 0, 0, 0, 0);
      cycle();

      // 5: write to r0 is dropped, then read r0.
      set_a(1, 0, 0, 1, 0, 32'hFFFF);
      cycle();
      set_a(1, 0, 0, 0, 0, 0);
      cycle();
      set_a(0, 0, 0, 0, 0, 0);
      cycle();

      // 6: B accepted, reset next cycle swallows its reply, then A wins first.
      set_b(1, 5, 7, 0, 0, 0);
      cycle();
      set_b(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      grant_log = "";
      set_a(1, 7, 5, 0, 0, 0);
      set_b(1, 5, 7, 0, 0, 0);
      cycle();
      check_eq("t6_a_first", 32'(grant_log == "A"), 32'd1);
      cycle();
      set_a(0, 0, 0, 0, 0, 0);
      set_b(0, 0, 0, 0, 0, 0);
      cycle();

      // Random traffic; a requester that was not granted keeps its payload.
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 59) == 0);
         if (!(a_valid && !a_won))
            set_a(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31)), $urandom);
         if (!(b_valid && !b_won))
            set_b(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31)), $urandom);
         cycle();
      end
      rst = 1'b0;
      set_a(0, 0, 0, 0, 0, 0);
      set_b(0, 0, 0, 0, 0, 0);
      cycle();
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
